// File: rtl/fft_peak_scanner.sv
// -----------------------------------------------------------------------------
// fft_peak_scanner
//
// Reads one FFT frame from the output dual-port BRAM after the FFT stage has
// finished writing it. The sweep uses BRAM port A in read-only mode and covers
// NUM_BINS consecutive bins, starting at BASE_BIN. For each bin the block
// computes the squared magnitude re^2 + im^2. It then reports the strongest
// bin's index and magnitude to the peak-pairing logic.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   single-cycle request to scan the frame held in BRAM
//   busy         out  high while a scan is in progress (start edge .. done fall)
//   done         out  one-cycle pulse when peak_bin/peak_mag are updated
//   bram_addr    out  BRAM port A address
//   bram_we      out  BRAM port A write enable, tied low
//   bram_q       in   BRAM port A read data, {real[DATA_W], imag[DATA_W]} signed
//   peak_bin     out  index of the largest-magnitude bin of the last scan
//   peak_mag     out  unsigned squared magnitude of that bin
//   result_valid out  high from the first done until reset or next accepted start
//
// Pipeline, for an address registered at edge k:
//   k   address issue  (issue_v_q)
//   k+1 BRAM read      (read_v_q / read_bin_q)
//   k+2 stage M        (mag_v_q / mag_bin_q / mag_q)
//   k+3 stage C        (best_mag_q / best_bin_q updated when strictly greater)
// With start sampled at edge E, done is high after edge E+NUM_BINS+3.
// -----------------------------------------------------------------------------
module fft_peak_scanner #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 8,
   parameter int BASE_BIN = 1,
   parameter int NUM_BINS = 2**(ADDR_W-1) - 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     bram_addr,
   output logic                  bram_we,
   input  logic [2*DATA_W-1:0]   bram_q,
   output logic [ADDR_W-1:0]     peak_bin,
   output logic [2*DATA_W-1:0]   peak_mag,
   output logic                  result_valid
);

   localparam int                MAG_W      = 2 * DATA_W;
   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_BIN);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_BIN + NUM_BINS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_DRAIN,
      S_DONE
   } state_t;

   // FSM state and registered outputs
   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                busy_q;
   logic                done_q;
   logic                result_valid_q;
   logic [ADDR_W-1:0]   peak_bin_q;
   logic [MAG_W-1:0]    peak_mag_q;

   // Running maximum of the scan in progress
   logic [ADDR_W-1:0]   best_bin_q;
   logic [MAG_W-1:0]    best_mag_q;

   // Read-valid / bin-index shift register that follows each issued address
   logic                issue_v_q;
   logic                read_v_q;
   logic [ADDR_W-1:0]   read_bin_q;
   logic                mag_v_q;
   logic [ADDR_W-1:0]   mag_bin_q;
   logic [MAG_W-1:0]    mag_q;

   // ---------------------------------------------------------------------------
   // Squared magnitude of the word currently on bram_q.
   // Each square of a signed DATA_W value is at most 2^(2*DATA_W-2), so the
   // sum (at most 2^(2*DATA_W-1)) fits in MAG_W bits when read as unsigned.
   // ---------------------------------------------------------------------------
   logic signed [DATA_W-1:0] re_s;
   logic signed [DATA_W-1:0] im_s;
   logic signed [MAG_W-1:0]  re_sq;
   logic signed [MAG_W-1:0]  im_sq;
   logic [MAG_W-1:0]         mag_d;

   assign re_s  = bram_q[2*DATA_W-1:DATA_W];
   assign im_s  = bram_q[DATA_W-1:0];
   // Sign-extend before multiplying so the product is the full-width square.
   assign re_sq = MAG_W'(re_s) * MAG_W'(re_s);
   assign im_sq = MAG_W'(im_s) * MAG_W'(im_s);
   assign mag_d = $unsigned(re_sq) + $unsigned(im_sq);

   // The pipeline is empty once no issued address remains in flight.
   logic pipe_empty;
   assign pipe_empty = !issue_v_q && !read_v_q && !mag_v_q;

   // ---------------------------------------------------------------------------
   // Read and magnitude stages
   // ---------------------------------------------------------------------------
   // NOTE: the reset is asynchronous and the sensitivity list includes the
   // reset edge, so every register listed here clears the moment reset_n
   // falls, including in the middle of a scan.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_v_q   <= 1'b0;
         read_bin_q <= '0;
         mag_v_q    <= 1'b0;
         mag_bin_q  <= '0;
         mag_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments: every stage samples the value its
         // predecessor held before this edge, which gives a true shift register.
         read_v_q   <= issue_v_q;
         read_bin_q <= addr_q;
         mag_v_q    <= read_v_q;
         mag_bin_q  <= read_bin_q;
         mag_q      <= mag_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM, address generator, compare stage and result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         addr_q         <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         result_valid_q <= 1'b0;
         peak_bin_q     <= '0;
         peak_mag_q     <= '0;
         best_bin_q     <= '0;
         best_mag_q     <= '0;
         issue_v_q      <= 1'b0;
      end else begin
         issue_v_q <= 1'b0;

         // Stage C. The comparison is strict, so on a tie the bin seen first
         // (the lower index) is kept.
         if (mag_v_q && (mag_q > best_mag_q)) begin
            best_mag_q <= mag_q;
            best_bin_q <= mag_bin_q;
         end

         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  // The pipeline is empty in IDLE, so clearing the running
                  // max here cannot race with stage C above.
                  best_mag_q     <= '0;
                  best_bin_q     <= FIRST_ADDR;
                  addr_q         <= FIRST_ADDR;
                  issue_v_q      <= 1'b1;
                  busy_q         <= 1'b1;
                  result_valid_q <= 1'b0;
                  state_q        <= S_SWEEP;
               end
            end

            S_SWEEP: begin
               if (addr_q == LAST_ADDR) begin
                  // The last bin has been issued. addr_q holds its value so
                  // it never wraps.
                  state_q <= S_DRAIN;
               end else begin
                  addr_q    <= addr_q + ADDR_W'(1);
                  issue_v_q <= 1'b1;
               end
            end

            S_DRAIN: begin
               if (pipe_empty) begin
                  // The last compare happened at the previous edge, so
                  // best_* is final.
                  peak_bin_q     <= best_bin_q;
                  peak_mag_q     <= best_mag_q;
                  result_valid_q <= 1'b1;
                  done_q         <= 1'b1;
                  state_q        <= S_DONE;
               end
            end

            S_DONE: begin
               // start is deliberately ignored here. A new scan may begin on
               // the first IDLE cycle.
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign bram_addr    = addr_q;
   assign bram_we      = 1'b0;
   assign peak_bin     = peak_bin_q;
   assign peak_mag     = peak_mag_q;
   assign result_valid = result_valid_q;

endmodule

// File: tb/tb_fft_peak_scanner.sv
// -----------------------------------------------------------------------------
// tb_fft_peak_scanner
//
// Self-checking bench for fft_peak_scanner with ADDR_W=4, DATA_W=8 and the
// default bins 1..7. A behavioural BRAM gives one cycle of synchronous read.
// Each accepted start pushes the reference peak, computed from the BRAM
// contents, plus the cycle in which done is expected. The monitor pops one
// entry and compares it on every done pulse.
// -----------------------------------------------------------------------------
module tb_fft_peak_scanner;

   localparam int ADDR_W   = 4;
   localparam int DATA_W   = 8;
   localparam int BASE_BIN = 1;
   localparam int NUM_BINS = 7;
   localparam int LAST_BIN = BASE_BIN + NUM_BINS - 1;

   logic                clk;
   logic                reset_n;
   logic                start;
   logic                busy;
   logic                done;
   logic [ADDR_W-1:0]   bram_addr;
   logic                bram_we;
   logic [2*DATA_W-1:0] bram_q;
   logic [ADDR_W-1:0]   peak_bin;
   logic [2*DATA_W-1:0] peak_mag;
   logic                result_valid;

   fft_peak_scanner #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .BASE_BIN(BASE_BIN),
      .NUM_BINS(NUM_BINS)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .bram_addr   (bram_addr),
      .bram_we     (bram_we),
      .bram_q      (bram_q),
      .peak_bin    (peak_bin),
      .peak_mag    (peak_mag),
      .result_valid(result_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural BRAM port A with one cycle of synchronous read
   logic [2*DATA_W-1:0] mem [2**ADDR_W];
   always @(posedge clk) bram_q <= mem[bram_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [ADDR_W-1:0]   bin;
      logic [2*DATA_W-1:0] mag;
      int                  cyc;
   } exp_t;

   exp_t sb[$];

   task automatic clear_mem();
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
   endtask

   // Reference peak: the strongest bin, with ties going to the lowest index.
   task automatic model(output logic [ADDR_W-1:0] b, output logic [2*DATA_W-1:0] m);
      int best;
      int best_b;
      best   = 0;
      best_b = BASE_BIN;
      for (int i = BASE_BIN; i <= LAST_BIN; i++) begin
         logic signed [DATA_W-1:0] re;
         logic signed [DATA_W-1:0] im;
         int mm;
         re = mem[i][2*DATA_W-1:DATA_W];
         im = mem[i][DATA_W-1:0];
         mm = int'(re) * int'(re) + int'(im) * int'(im);
         if (mm > best) begin
            best   = mm;
            best_b = i;
         end
      end
      b = ADDR_W'(best_b);
      m = (2*DATA_W)'(best);
   endtask

   // Push the expectation for a start sampled at edge e_edge.
   task automatic push_exp(input int e_edge);
      exp_t e;
      model(e.bin, e.mag);
      e.cyc = e_edge + NUM_BINS + 3;
      sb.push_back(e);
   endtask

   // Called at a negedge. Returns at the negedge after the start edge E.
   task automatic pulse_start();
      push_exp(cyc + 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) check("done_timeout", 64'd0, 64'd1);
   endtask

   // Monitor: samples on the falling edge
   int   done_cnt  = 0;
   int   bad_addr  = 0;
   int   we_seen   = 0;
   logic prev_done = 1'b0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (busy && (int'(bram_addr) < BASE_BIN || int'(bram_addr) > LAST_BIN)) bad_addr++;
         if (bram_we) we_seen++;
         if (done) begin
            exp_t e;
            done_cnt++;
            check("done_width", prev_done, 1'b0);
            if (sb.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("peak_bin", peak_bin, e.bin);
               check("peak_mag", peak_mag, e.mag);
               check("result_valid", result_valid, 1'b1);
               check("done_cycle", cyc, e.cyc);
            end
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   int base_cnt;

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      clear_mem();

      // 1. Reset, then idle
      repeat (3) begin
         @(negedge clk);
         check("reset_idle", {busy, done, result_valid, bram_we}, 4'b0000);
      end
      reset_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("idle", {busy, done, result_valid, bram_we}, 4'b0000);
      end

      // 2. Single peak at bin 5 = (3, -4), magnitude 25
      clear_mem();
      mem[5] = 16'h03FC;
      pulse_start();
      for (int i = 0; i < NUM_BINS; i++) begin
         check("addr_step", bram_addr, 4'(BASE_BIN + i));
         @(negedge clk);
      end
      wait_done();
      @(negedge clk);

      // 3. Tie at the most negative extreme: bins 2 and 6 = (-128, -128)
      clear_mem();
      mem[2] = 16'h8080;
      mem[3] = 16'h0505;
      mem[6] = 16'h8080;
      mem[7] = 16'hF603;
      pulse_start();
      wait_done();
      repeat (4) @(negedge clk);
      check("peak_hold", {peak_bin, peak_mag}, {4'd2, 16'd32768});

      // 4. start while busy is ignored
      base_cnt = done_cnt;
      pulse_start();
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (6) @(negedge clk);
      check("one_done", done_cnt, base_cnt + 1);

      // 5. Asynchronous reset in the middle of a scan
      clear_mem();
      mem[5] = 16'h03FC;
      pulse_start();
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b0;
      #1 check("async_reset",
               {busy, done, result_valid, bram_we, bram_addr, peak_bin, peak_mag},
               '0);
      sb.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_reset_rv", result_valid, 1'b0);
      pulse_start();
      wait_done();

      // 6. Back-to-back scan. start is held through the DONE cycle, which is
      //    ignored, and is accepted in the first IDLE cycle. Bin 0 is loaded
      //    with a large value that the scan must skip.
      clear_mem();
      mem[0] = 16'h6464;
      mem[1] = 16'h0100;
      mem[7] = 16'hEC0F;
      push_exp(cyc + 2);
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      check("rv_drop", result_valid, 1'b0);
      check("peak_hold_b2b", {peak_bin, peak_mag}, {4'd5, 16'd25});
      wait_done();
      repeat (4) @(negedge clk);

      check("no_dc_or_overrun", bad_addr, 0);
      check("we_never", we_seen, 0);
      check("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
